// File: rtl/lvds_rx_frame_checker_if.sv
// Symbol stream from the 8b/10b decoder into the frame checker, plus the
// checker's payload stream, frame status and bring-up counters.
interface lvds_rx_frame_checker_if;
  logic        din_valid;
  logic        kin;
  logic [7:0]  datain;
  logic        code_err;
  logic        link_locked;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        sof;
  logic        eof;
  logic        frame_done;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  // Decoder side: drives symbols, observes checker results.
  modport master (
    output din_valid, kin, datain, code_err,
    input  link_locked, dout, dout_valid, sof, eof,
    input  frame_done, frame_ok, frame_err, frame_cnt, err_cnt
  );

  // Checker side: consumes symbols, drives results.
  modport slave (
    input  din_valid, kin, datain, code_err,
    output link_locked, dout, dout_valid, sof, eof,
    output frame_done, frame_ok, frame_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/lvds_rx_frame_checker.sv
// Receive-side frame checker for the 8b/10b LVDS link: acquires comma lock,
// finds the two-byte header, streams the payload out and checks it against
// an incrementing byte pattern, with saturating frame and error counters.
module lvds_rx_frame_checker #(
  parameter logic [7:0] COMMA_8B    = 8'hBC,
  parameter logic [7:0] HDR0        = 8'hEE,
  parameter logic [7:0] HDR1        = 8'h33,
  parameter int         PAYLOAD_LEN = 124,
  parameter int         LOCK_COMMAS = 4,
  parameter int         UNLOCK_ERRS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lvds_rx_frame_checker_if.slave  bus
);
  localparam int CCW = $clog2(LOCK_COMMAS + 1);
  localparam int ECW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {ST_UNLOCK, ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

  state_t          state_reg, state_next;
  logic [CCW-1:0]  comma_cnt_reg, comma_cnt_next;
  logic [ECW-1:0]  consec_err_reg, consec_err_next;
  logic [7:0]      byte_cnt_reg, byte_cnt_next;
  logic [7:0]      expected_reg, expected_next;
  logic            mismatch_reg, mismatch_next;
  logic            locked_reg, locked_next;
  logic [7:0]      dout_reg, dout_next;
  logic            dout_valid_reg, dout_valid_next;
  logic            sof_reg, sof_next;
  logic            eof_reg, eof_next;
  logic            frame_done_reg, frame_done_next;
  logic            frame_ok_reg, frame_ok_next;
  logic            frame_err_reg, frame_err_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic [15:0]     err_cnt_reg, err_cnt_next;

  logic is_comma;
  logic last_byte;
  logic err_inc;
  logic bad_byte;

  assign is_comma  = bus.kin && (bus.datain == COMMA_8B) && !bus.code_err;
  assign last_byte = (byte_cnt_reg == 8'(PAYLOAD_LEN - 1));

  // Next-state and registered-output values; every error source in a cycle
  // collapses into a single err_inc so err_cnt advances by at most one.
  always_comb begin
    state_next      = state_reg;
    comma_cnt_next  = comma_cnt_reg;
    consec_err_next = consec_err_reg;
    byte_cnt_next   = byte_cnt_reg;
    expected_next   = expected_reg;
    mismatch_next   = mismatch_reg;
    locked_next     = locked_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    sof_next        = 1'b0;
    eof_next        = 1'b0;
    frame_done_next = 1'b0;
    frame_ok_next   = 1'b0;
    frame_err_next  = 1'b0;
    frame_cnt_next  = frame_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    err_inc         = 1'b0;
    bad_byte        = 1'b0;

    if (bus.din_valid) begin
      if (bus.code_err) begin
        if (consec_err_reg != ECW'(UNLOCK_ERRS))
          consec_err_next = consec_err_reg + 1'b1;
        if (locked_reg)
          err_inc = 1'b1;
      end else begin
        consec_err_next = '0;
      end

      if (bus.code_err && (state_reg != ST_UNLOCK) &&
          (consec_err_reg == ECW'(UNLOCK_ERRS - 1))) begin
        // Error burst: lose lock, abort any frame in flight.
        state_next     = ST_UNLOCK;
        locked_next    = 1'b0;
        comma_cnt_next = '0;
        if ((state_reg == ST_HDR) || (state_reg == ST_PAYLOAD))
          frame_err_next = 1'b1;
      end else begin
        unique case (state_reg)
          ST_UNLOCK: begin
            if (!is_comma) begin
              comma_cnt_next = '0;
            end else if (comma_cnt_reg == CCW'(LOCK_COMMAS - 1)) begin
              comma_cnt_next = '0;
              locked_next    = 1'b1;
              state_next     = ST_IDLE;
            end else begin
              comma_cnt_next = comma_cnt_reg + 1'b1;
            end
          end
          ST_IDLE: begin
            if (!bus.kin && (bus.datain == HDR0)) begin
              state_next = ST_HDR;
            end else if (!is_comma) begin
              frame_err_next = 1'b1;
              err_inc        = 1'b1;
            end
          end
          ST_HDR: begin
            if (!bus.kin && (bus.datain == HDR1)) begin
              state_next    = ST_PAYLOAD;
              expected_next = HDR1 + 8'd1;
              byte_cnt_next = '0;
              mismatch_next = 1'b0;
            end else begin
              frame_err_next = 1'b1;
              err_inc        = 1'b1;
              state_next     = ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            if (bus.kin) begin
              // Truncated frame; a K-symbol can never start a new header.
              frame_err_next = 1'b1;
              err_inc        = 1'b1;
              state_next     = ST_IDLE;
            end else begin
              dout_next       = bus.datain;
              dout_valid_next = 1'b1;
              sof_next        = (byte_cnt_reg == 8'd0);
              eof_next        = last_byte;
              bad_byte        = bus.code_err || (bus.datain != expected_reg);
              if (bad_byte)
                err_inc = 1'b1;
              mismatch_next = mismatch_reg || bad_byte;
              expected_next = expected_reg + 8'd1;
              byte_cnt_next = byte_cnt_reg + 8'd1;
              if (last_byte) begin
                frame_done_next = 1'b1;
                frame_ok_next   = !(mismatch_reg || bad_byte);
                if (frame_cnt_reg != 16'hFFFF)
                  frame_cnt_next = frame_cnt_reg + 16'd1;
                state_next = ST_IDLE;
              end
            end
          end
          default: state_next = ST_UNLOCK;
        endcase
      end
    end

    if (err_inc && (err_cnt_reg != 16'hFFFF))
      err_cnt_next = err_cnt_reg + 16'd1;
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_UNLOCK;
      comma_cnt_reg  <= '0;
      consec_err_reg <= '0;
      byte_cnt_reg   <= '0;
      expected_reg   <= '0;
      mismatch_reg   <= 1'b0;
      locked_reg     <= 1'b0;
      dout_reg       <= 8'h00;
      dout_valid_reg <= 1'b0;
      sof_reg        <= 1'b0;
      eof_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      comma_cnt_reg  <= comma_cnt_next;
      consec_err_reg <= consec_err_next;
      byte_cnt_reg   <= byte_cnt_next;
      expected_reg   <= expected_next;
      mismatch_reg   <= mismatch_next;
      locked_reg     <= locked_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      sof_reg        <= sof_next;
      eof_reg        <= eof_next;
      frame_done_reg <= frame_done_next;
      frame_ok_reg   <= frame_ok_next;
      frame_err_reg  <= frame_err_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  assign bus.link_locked = locked_reg;
  assign bus.dout        = dout_reg;
  assign bus.dout_valid  = dout_valid_reg;
  assign bus.sof         = sof_reg;
  assign bus.eof         = eof_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_ok    = frame_ok_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.frame_cnt   = frame_cnt_reg;
  assign bus.err_cnt     = err_cnt_reg;
endmodule

// File: tb/tb_lvds_rx_frame_checker.sv
// Directed bench for lvds_rx_frame_checker: expected per-symbol results are
// queued as symbols are driven and compared when the registered outputs appear.
module tb_lvds_rx_frame_checker;
  logic clk;
  logic rst_n;

  lvds_rx_frame_checker_if i124();
  lvds_rx_frame_checker_if i255();

  lvds_rx_frame_checker #(.PAYLOAD_LEN(124)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i124)
  );

  lvds_rx_frame_checker #(.PAYLOAD_LEN(255)) dut255 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i255)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic        locked;
    logic        dv;
    logic [7:0]  dout;
    logic        sof;
    logic        eof;
    logic        done;
    logic        ok;
    logic        ferr;
    logic [15:0] fcnt;
    logic [15:0] ecnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_x;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic        x_locked[2];
  logic [15:0] x_fcnt[2];
  logic [15:0] x_ecnt[2];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one decoded symbol into the selected DUT and queue its expected result.
  task automatic sym(input bit sel, input logic k, input logic [7:0] d, input logic e,
                     input logic dv, input logic sof, input logic eof,
                     input logic done, input logic ok, input logic ferr);
    exp_t x;
    @(negedge clk);
    i124.din_valid = (sel == 1'b0);
    i255.din_valid = (sel == 1'b1);
    i124.kin = k;  i124.datain = d;  i124.code_err = e;
    i255.kin = k;  i255.datain = d;  i255.code_err = e;
    x.sel = sel;  x.locked = x_locked[sel];  x.dv = dv;  x.dout = d;
    x.sof = sof;  x.eof = eof;  x.done = done;  x.ok = ok;  x.ferr = ferr;
    x.fcnt = x_fcnt[sel];  x.ecnt = x_ecnt[sel];
    q.push_back(x);
  endtask

  // Idle cycle: nothing valid, state must hold and pulses must be low.
  task automatic idle(input bit sel);
    exp_t x;
    @(negedge clk);
    i124.din_valid = 1'b0;
    i255.din_valid = 1'b0;
    x.sel = sel;  x.locked = x_locked[sel];  x.dv = 1'b0;  x.dout = 8'h00;
    x.sof = 1'b0;  x.eof = 1'b0;  x.done = 1'b0;  x.ok = 1'b0;  x.ferr = 1'b0;
    x.fcnt = x_fcnt[sel];  x.ecnt = x_ecnt[sel];
    q.push_back(x);
  endtask

  task automatic comma(input bit sel);
    sym(sel, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full frame; byte at index cidx (if >= 0) is replaced by cval.
  task automatic send_frame(input bit sel, input int len, input logic [7:0] start,
                            input int cidx, input logic [7:0] cval);
    logic [7:0] d;
    logic       bad_any;
    logic       last;
    bad_any = 1'b0;
    sym(sel, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sym(sel, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(sel);
    for (int i = 0; i < len; i++) begin
      d = 8'(int'(start) + i);
      if (i == cidx) begin
        d = cval;
        bad_any = 1'b1;
        x_ecnt[sel] = sat_inc(x_ecnt[sel]);
      end
      last = (i == len - 1);
      if (last) x_fcnt[sel] = sat_inc(x_fcnt[sel]);
      sym(sel, 1'b0, d, 1'b0, 1'b1, (i == 0), last, last, last && !bad_any, 1'b0);
    end
  endtask

  // Compare the registered outputs 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      n_txn++;
      if (mon_x.sel) begin
        $display("txn %0d dut255 locked=%0b dv=%0b dout=%h sof=%0b eof=%0b done=%0b ok=%0b ferr=%0b fcnt=%h ecnt=%h",
                 n_txn, i255.link_locked, i255.dout_valid, i255.dout, i255.sof, i255.eof,
                 i255.frame_done, i255.frame_ok, i255.frame_err, i255.frame_cnt, i255.err_cnt);
        chk("locked255", 16'(i255.link_locked), 16'(mon_x.locked));
        chk("dv255",     16'(i255.dout_valid),  16'(mon_x.dv));
        if (mon_x.dv) chk("dout255", 16'(i255.dout), 16'(mon_x.dout));
        chk("sof255",    16'(i255.sof),         16'(mon_x.sof));
        chk("eof255",    16'(i255.eof),         16'(mon_x.eof));
        chk("done255",   16'(i255.frame_done),  16'(mon_x.done));
        chk("ok255",     16'(i255.frame_ok),    16'(mon_x.ok));
        chk("ferr255",   16'(i255.frame_err),   16'(mon_x.ferr));
        chk("fcnt255",   i255.frame_cnt,        mon_x.fcnt);
        chk("ecnt255",   i255.err_cnt,          mon_x.ecnt);
      end else begin
        $display("txn %0d dut124 locked=%0b dv=%0b dout=%h sof=%0b eof=%0b done=%0b ok=%0b ferr=%0b fcnt=%h ecnt=%h",
                 n_txn, i124.link_locked, i124.dout_valid, i124.dout, i124.sof, i124.eof,
                 i124.frame_done, i124.frame_ok, i124.frame_err, i124.frame_cnt, i124.err_cnt);
        chk("locked", 16'(i124.link_locked), 16'(mon_x.locked));
        chk("dv",     16'(i124.dout_valid),  16'(mon_x.dv));
        if (mon_x.dv) chk("dout", 16'(i124.dout), 16'(mon_x.dout));
        chk("sof",    16'(i124.sof),         16'(mon_x.sof));
        chk("eof",    16'(i124.eof),         16'(mon_x.eof));
        chk("done",   16'(i124.frame_done),  16'(mon_x.done));
        chk("ok",     16'(i124.frame_ok),    16'(mon_x.ok));
        chk("ferr",   16'(i124.frame_err),   16'(mon_x.ferr));
        chk("fcnt",   i124.frame_cnt,        mon_x.fcnt);
        chk("ecnt",   i124.err_cnt,          mon_x.ecnt);
      end
    end
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      x_locked[s] = 1'b0;
      x_fcnt[s]   = 16'h0000;
      x_ecnt[s]   = 16'h0000;
    end
    i124.din_valid = 1'b0; i124.kin = 1'b0; i124.datain = 8'h00; i124.code_err = 1'b0;
    i255.din_valid = 1'b0; i255.kin = 1'b0; i255.datain = 8'h00; i255.code_err = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_locked", 16'(i124.link_locked), 16'h0);
    chk("rst_dout",   16'(i124.dout),        16'h0);
    chk("rst_dv",     16'(i124.dout_valid),  16'h0);
    chk("rst_sof",    16'(i124.sof),         16'h0);
    chk("rst_eof",    16'(i124.eof),         16'h0);
    chk("rst_done",   16'(i124.frame_done),  16'h0);
    chk("rst_ok",     16'(i124.frame_ok),    16'h0);
    chk("rst_ferr",   16'(i124.frame_err),   16'h0);
    chk("rst_fcnt",   i124.frame_cnt,        16'h0);
    chk("rst_ecnt",   i124.err_cnt,          16'h0);
    chk("rst_fcnt255", i255.frame_cnt,       16'h0);
    rst_n = 1'b1;

    // 1: lock after exactly four commas, further commas silent
    for (int i = 0; i < 10; i++) begin
      if (i == 3) x_locked[0] = 1'b1;
      comma(1'b0);
    end

    // 2: clean frame
    send_frame(1'b0, 124, 8'h34, -1, 8'h00);
    comma(1'b0);

    // 3: byte 50 corrupted, later bytes still compared against prediction
    send_frame(1'b0, 124, 8'h34, 50, 8'h00);
    comma(1'b0);

    // 4: header fault, then truncated payload
    sym(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    x_ecnt[0] = sat_inc(x_ecnt[0]);
    comma_ferr: sym(1'b0, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sym(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sym(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      sym(1'b0, 1'b0, 8'(8'h34 + i), 1'b0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
    x_ecnt[0] = sat_inc(x_ecnt[0]);
    sym(1'b0, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    comma(1'b0);

    // Back-to-back frames with no comma between them
    send_frame(1'b0, 124, 8'h34, -1, 8'h00);
    send_frame(1'b0, 124, 8'h34, -1, 8'h00);
    comma(1'b0);

    // 5a: three code errors keep lock; each is also a stray idle symbol
    for (int i = 0; i < 3; i++) begin
      x_ecnt[0] = sat_inc(x_ecnt[0]);
      sym(1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    comma(1'b0);

    // 5b: four code errors inside a payload drop lock with one frame_err
    sym(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sym(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      sym(1'b0, 1'b0, 8'(8'h34 + i), 1'b0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) begin
      x_ecnt[0] = sat_inc(x_ecnt[0]);
      sym(1'b0, 1'b0, 8'(8'h34 + i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    x_ecnt[0] = sat_inc(x_ecnt[0]);
    x_locked[0] = 1'b0;
    sym(1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) x_locked[0] = 1'b1;
      comma(1'b0);
    end

    // 6a: 255-byte payload wrapping 0xFF -> 0x00
    for (int i = 0; i < 4; i++) begin
      if (i == 3) x_locked[1] = 1'b1;
      comma(1'b1);
    end
    send_frame(1'b1, 255, 8'h34, -1, 8'h00);
    comma(1'b1);

    // 6b: frame counter saturation
    idle(1'b0);
    @(posedge clk);
    #2;
    force dut.frame_cnt_reg = 16'hFFFE;
    #1;
    release dut.frame_cnt_reg;
    x_fcnt[0] = 16'hFFFE;
    for (int i = 0; i < 3; i++)
      send_frame(1'b0, 124, 8'h34, -1, 8'h00);
    comma(1'b0);
    idle(1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
